add_pe_pipe: RTL and testbench

- Parametrised, pipelined successor to the tile's combinational half adder; the arithmetic processing element of a CGRA tile.
- Accepts operand pairs over a valid/ready handshake and computes one of four ops: ADD, SUB, CHAIN, ACC.
- Returns result plus carry through a 2-stage elastic pipeline.
- Honours the tile on_off gate and an external carry input (carry_listen), and keeps internal carry/accumulator state for multi-word and running-sum operation.

---
 rtl/add_pe_pipe.sv | 190 +++++++++++++++++++
 tb/tb_add_pe_pipe.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pe_pipe.sv
// ---------------------------------------------------------------------------
// add_pe_pipe
//   Arithmetic processing element of a CGRA tile. Operand pairs arrive over a
//   valid/ready handshake, pass through a two-stage elastic pipeline and come
//   out as {c, carry_out}. Four operations are supported:
//     ADD   : a + b + (carry_in & carry_listen)
//     SUB   : a + ~b + 1, carry_out = no-borrow (a >= b)
//     CHAIN : a + b + chain carry left by the previous ADD/SUB/CHAIN
//     ACC   : running sum acc + a (b ignored), result becomes the new acc
//
// Optional build macro:
//   ADD_PE_SAT_EN - saturate c (all-ones on carry for ADD/CHAIN/ACC, zero on
//                   borrow for SUB). Without it results wrap modulo 2^WIDTH.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   on_off            tile enable, 0 freezes the whole block
//   clr               synchronous clear of acc and chain carry (on_off=1)
//   in_valid/in_ready operand beat handshake
//   a, b, mode        operands and op select, sampled on accept
//   carry_in          external carry, used by ADD when carry_listen=1
//   carry_listen      ADD carry enable, sampled on accept
//   out_valid/out_ready result beat handshake
//   c, carry_out      registered result and carry / no-borrow
// ---------------------------------------------------------------------------
module add_pe_pipe #(
   parameter int unsigned      WIDTH    = 8,
   parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             on_off,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   input  logic             carry_in,
   input  logic             carry_listen,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             carry_out
);

   localparam logic [1:0] MODE_ADD   = 2'b00;
   localparam logic [1:0] MODE_SUB   = 2'b01;
   localparam logic [1:0] MODE_CHAIN = 2'b10;
   localparam logic [1:0] MODE_ACC   = 2'b11;

   // Stage 1: captured operands
   logic             s1_valid_r;
   logic [WIDTH-1:0] s1_a_r;
   logic [WIDTH-1:0] s1_b_r;
   logic [1:0]       s1_mode_r;
   logic             s1_cin_r;

   // Stage 2: result register
   logic             s2_valid_r;
   logic [WIDTH-1:0] c_r;
   logic             carry_r;

   // Persistent arithmetic state
   logic [WIDTH-1:0] acc_r;
   logic             chain_r;

   logic             clr_s;
   logic             accept_s;
   logic             s2_load_s;
   logic             s2_consume_s;
   logic [WIDTH-1:0] acc_eff_s;
   logic             chain_eff_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] res_s;

   // clr is only honoured while the tile is enabled
   assign clr_s        = on_off & clr;
   assign s2_consume_s = on_off & s2_valid_r & out_ready;
   assign s2_load_s    = on_off & s1_valid_r & (~s2_valid_r | s2_consume_s);
   // rst_n is folded in so in_ready reads 0 during reset even though S1 is empty
   assign in_ready     = rst_n & on_off & (~s1_valid_r | s2_load_s);
   assign accept_s     = in_valid & in_ready;
   assign out_valid    = on_off & s2_valid_r;
   assign c            = c_r;
   assign carry_out    = carry_r;

   // State as seen by a beat loading S2: a same-cycle clr takes effect first
   always_comb begin
      acc_eff_s   = acc_r;
      chain_eff_s = chain_r;
      if (clr_s) begin
         acc_eff_s   = ACC_INIT;
         chain_eff_s = 1'b0;
      end else begin
         acc_eff_s   = acc_r;
         chain_eff_s = chain_r;
      end
   end

   // WIDTH+1 bit arithmetic for the op held in S1
   always_comb begin
      sum_s = {(WIDTH+1){1'b0}};
      case (s1_mode_r)
         MODE_ADD:   sum_s = {1'b0, s1_a_r} + {1'b0, s1_b_r} + {{WIDTH{1'b0}}, s1_cin_r};
         MODE_SUB:   sum_s = {1'b0, s1_a_r} + {1'b0, ~s1_b_r} + {{WIDTH{1'b0}}, 1'b1};
         MODE_CHAIN: sum_s = {1'b0, s1_a_r} + {1'b0, s1_b_r} + {{WIDTH{1'b0}}, chain_eff_s};
         MODE_ACC:   sum_s = {1'b0, acc_eff_s} + {1'b0, s1_a_r};
         default:    sum_s = {(WIDTH+1){1'b0}};
      endcase
   end

   // Result formatting: wrap, or clamp when saturation is compiled in
   always_comb begin
      res_s = sum_s[WIDTH-1:0];
`ifdef ADD_PE_SAT_EN
      if (s1_mode_r == MODE_SUB) begin
         // carry bit low on SUB means a borrow occurred
         if (sum_s[WIDTH]) begin
            res_s = sum_s[WIDTH-1:0];
         end else begin
            res_s = {WIDTH{1'b0}};
         end
      end else begin
         if (sum_s[WIDTH]) begin
            res_s = {WIDTH{1'b1}};
         end else begin
            res_s = sum_s[WIDTH-1:0];
         end
      end
`else
      res_s = sum_s[WIDTH-1:0];
`endif
   end

   // Stage 1 register: take a new beat or empty when it moves on
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= {WIDTH{1'b0}};
         s1_b_r     <= {WIDTH{1'b0}};
         s1_mode_r  <= 2'b00;
         s1_cin_r   <= 1'b0;
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         s1_a_r     <= a;
         s1_b_r     <= b;
         s1_mode_r  <= mode;
         s1_cin_r   <= carry_in & carry_listen;
      end else if (s2_load_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // Stage 2 register: results hold steady until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         c_r        <= {WIDTH{1'b0}};
         carry_r    <= 1'b0;
      end else if (s2_load_s) begin
         s2_valid_r <= 1'b1;
         c_r        <= res_s;
         carry_r    <= sum_s[WIDTH];
      end else if (s2_consume_s) begin
         s2_valid_r <= 1'b0;
      end
   end

   // Accumulator and chain carry; a loading beat updates its own field and
   // the other field picks up any same-cycle clr through the *_eff values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r   <= ACC_INIT;
         chain_r <= 1'b0;
      end else if (s2_load_s) begin
         if (s1_mode_r == MODE_ACC) begin
            acc_r   <= res_s;
            chain_r <= chain_eff_s;
         end else begin
            acc_r   <= acc_eff_s;
            chain_r <= sum_s[WIDTH];
         end
      end else if (clr_s) begin
         acc_r   <= ACC_INIT;
         chain_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_add_pe_pipe.sv
`timescale 1ns/1ps
module tb_add_pe_pipe;
   localparam int W = 8;
   localparam int MOD = 1 << W;
   localparam logic [W-1:0] AINIT = 8'd0;

   logic clk = 1'b0;
   logic rst_n, on_off, clr, in_valid, in_ready, carry_in, carry_listen;
   logic out_valid, out_ready, carry_out;
   logic [W-1:0] a, b, c;
   logic [1:0] mode;

   always #5 clk = ~clk;

   add_pe_pipe #(.WIDTH(W), .ACC_INIT(AINIT)) dut (
      .clk(clk), .rst_n(rst_n), .on_off(on_off), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .mode(mode),
      .carry_in(carry_in), .carry_listen(carry_listen),
      .out_valid(out_valid), .out_ready(out_ready), .c(c), .carry_out(carry_out)
   );

   typedef struct {
      logic [W-1:0] c;
      logic         co;
      int           cyc;
      bit           lat;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int m_acc = 0;
   int m_chain = 0;
   int acc_cnt = 0;
   bit want_lat = 1'b0;
   bit en_rand = 1'b0;
   bit hold_v = 1'b0;
   logic [W-1:0] hold_c;
   logic hold_co;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: operations take effect in acceptance order
   function automatic void model_push(input int ai, input int bi, input int md, input int cin);
      int s;
      int r;
      int co;
      exp_t e;
      s = 0; r = 0; co = 0;
      case (md)
         0: s = ai + bi + cin;
         2: s = ai + bi + m_chain;
         3: s = m_acc + ai;
         default: s = 0;
      endcase
      if (md == 1) begin
         co = (ai >= bi) ? 1 : 0;
         r  = (ai - bi + MOD) % MOD;
`ifdef ADD_PE_SAT_EN
         if (co == 0) r = 0;
`endif
      end else begin
         co = (s >= MOD) ? 1 : 0;
         r  = s % MOD;
`ifdef ADD_PE_SAT_EN
         if (co == 1) r = MOD - 1;
`endif
      end
      if (md == 3) m_acc = r;
      else m_chain = co;
      e.c = r[W-1:0];
      e.co = co[0];
      e.cyc = cyc;
      e.lat = want_lat;
      sb.push_back(e);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: model updates on accept, scoreboard pops on output handshake
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         check("rst_out_valid", int'(out_valid), 0);
         check("rst_c", int'(c), 0);
         check("rst_carry_out", int'(carry_out), 0);
         check("rst_in_ready", int'(in_ready), 0);
         hold_v = 1'b0;
      end else begin
         if (on_off && clr) begin
            m_acc = int'(AINIT);
            m_chain = 0;
         end
         if (in_valid && in_ready) begin
            model_push(int'(a), int'(b), int'(mode), int'(carry_in & carry_listen));
            acc_cnt++;
         end
         if (!on_off) begin
            check("stall_out_valid", int'(out_valid), 0);
            check("stall_in_ready", int'(in_ready), 0);
         end else begin
            if (out_valid && hold_v) begin
               check("hold_c", int'(c), int'(hold_c));
               check("hold_carry_out", int'(carry_out), int'(hold_co));
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output: got c=%0d with empty scoreboard", c);
               end else begin
                  e = sb.pop_front();
                  check("result_c", int'(c), int'(e.c));
                  check("result_carry_out", int'(carry_out), int'(e.co));
                  if (e.lat) check("latency", cyc - e.cyc, 2);
               end
            end
            hold_v = out_valid && !out_ready;
            hold_c = c;
            hold_co = carry_out;
         end
      end
   end

   // Random backpressure and tile gating during the random phase
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (en_rand) begin
            out_ready = (($urandom % 4) != 0);
            on_off = (($urandom % 8) != 0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_accept();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: in_ready stayed 0, required 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic set_beat(input int ai, input int bi, input int md, input bit ci, input bit li);
      a = ai[W-1:0];
      b = bi[W-1:0];
      mode = md[1:0];
      carry_in = ci;
      carry_listen = li;
      in_valid = 1'b1;
   endtask

   task automatic beat(input int ai, input int bi, input int md, input bit ci, input bit li);
      set_beat(ai, bi, md, ci, li);
      wait_accept();
   endtask

   task automatic drain();
      for (int t = 0; t < 200; t++) begin
         if (sb.size() == 0) break;
         tick(1);
      end
      check("drain_empty", sb.size(), 0);
      tick(1);
   endtask

   initial begin
      int base;
      rst_n = 1'b0; on_off = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; mode = 2'b00; carry_in = 1'b0; carry_listen = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      tick(1);

      // Directed arithmetic
      want_lat = 1'b1;
      beat(5, 10, 0, 1'b0, 1'b0);
      beat(250, 21, 0, 1'b0, 1'b0);
      beat(255, 0, 0, 1'b1, 1'b1);
      beat(0, 0, 2, 1'b0, 1'b0);
      beat(3, 5, 1, 1'b0, 1'b0);
      beat(5, 5, 1, 1'b0, 1'b0);
      drain();

      // Accumulator after clr
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      for (int i = 0; i < 3; i++) beat(100, int'($urandom % 256), 3, 1'b0, 1'b0);
      drain();

      // Backpressure: two beats buffered, third held off
      want_lat = 1'b0;
      out_ready = 1'b0;
      base = acc_cnt;
      beat(1, 2, 0, 1'b0, 1'b0);
      beat(30, 4, 1, 1'b0, 1'b0);
      set_beat(7, 8, 0, 1'b0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", int'(in_ready), 0);
      end
      check("bp_accept_count", acc_cnt - base, 2);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_accept();
      drain();

      // Stall with two beats in flight; clr during stall must be ignored
      beat(10, 0, 3, 1'b0, 1'b0);
      beat(200, 100, 2, 1'b0, 1'b0);
      on_off = 1'b0;
      clr = 1'b1;
      tick(4);
      clr = 1'b0;
      on_off = 1'b1;
      beat(50, 0, 3, 1'b0, 1'b0);
      beat(1, 1, 2, 1'b0, 1'b0);
      drain();

      // Asynchronous reset mid-stream
      beat(9, 9, 0, 1'b0, 1'b0);
      beat(7, 7, 3, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", int'(out_valid), 0);
      check("async_rst_c", int'(c), 0);
      check("async_rst_carry_out", int'(carry_out), 0);
      check("async_rst_in_ready", int'(in_ready), 0);
      sb.delete();
      m_acc = int'(AINIT);
      m_chain = 0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick(1);
      want_lat = 1'b1;
      beat(1, 0, 3, 1'b0, 1'b0);
      beat(0, 0, 2, 1'b0, 1'b0);
      drain();

      // Random traffic with random backpressure and gating
      want_lat = 1'b0;
      en_rand = 1'b1;
      for (int i = 0; i < 400; i++)
         beat(int'($urandom % 256), int'($urandom % 256), int'($urandom % 4),
              1'(($urandom % 2) != 0), 1'(($urandom % 2) != 0));
      en_rand = 1'b0;
      tick(1);
      out_ready = 1'b1;
      on_off = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
